// File: rtl/eth_tx_arbiter_n.sv
// GMII transmit arbiter: grants one of PORT_NUM sources at a time (fixed priority
// or round-robin), muxes its tx_en/txd, and enforces an inter-frame gap and an optional grant timeout.
module eth_tx_arbiter_n #(
    parameter int PORT_NUM       = 3,
    parameter int RR_MODE        = 1,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int ID_W          = ($clog2(PORT_NUM) > 1) ? $clog2(PORT_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [PORT_NUM-1:0]   port_req,
    input  logic [PORT_NUM-1:0]   port_done,
    output logic [PORT_NUM-1:0]   port_sel,
    input  logic [PORT_NUM-1:0]   port_tx_en,
    input  logic [8*PORT_NUM-1:0] port_txd,
    output logic                  gmii_tx_en,
    output logic [7:0]            gmii_txd,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy,
    output logic                  timeout_pulse
);

    localparam int CNT_MAX = (IFG_CYCLES > TIMEOUT_CYCLES) ? IFG_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [PORT_NUM-1:0] r_port_sel;
    logic                r_tx_en;
    logic [7:0]          r_txd;

    logic [7:0]          w_txd_arr [PORT_NUM];
    logic                w_done;
    logic                w_sel_en;
    logic [7:0]          w_sel_txd;
    logic                w_timeout;
    logic [ID_W-1:0]     w_start;
    logic [ID_W-1:0]     w_winner;
    logic [ID_W-1:0]     w_ptr_next;
    logic [ID_W:0]       w_cand;
    logic                w_found;
    logic [PORT_NUM-1:0] w_onehot;

    generate
        for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_txd_unpack
            assign w_txd_arr[gi] = port_txd[8*gi +: 8];
        end
    endgenerate

    assign w_done    = port_done[r_grant_id];
    assign w_sel_en  = port_tx_en[r_grant_id];
    assign w_sel_txd = w_txd_arr[r_grant_id];

    // A done in the same cycle as the last allowed grant cycle suppresses the timeout.
    assign w_timeout = TO_EN && (r_state == ST_GRANT) && (r_cnt == TO_LAST) && !w_done;

    assign w_start = (RR_MODE != 0) ? r_rr_ptr : '0;

    // Scan all ports starting at w_start, wrapping, and take the first requester.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < PORT_NUM; k++) begin
            w_cand = {1'b0, w_start} + (ID_W+1)'(k);
            if (w_cand >= (ID_W+1)'(PORT_NUM)) begin
                w_cand = w_cand - (ID_W+1)'(PORT_NUM);
            end
            if (!w_found && port_req[w_cand[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[ID_W-1:0];
            end
        end
    end

    assign w_ptr_next = (w_winner == ID_W'(PORT_NUM - 1)) ? '0 : w_winner + 1'b1;
    assign w_onehot   = {{(PORT_NUM-1){1'b0}}, 1'b1} << w_winner;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_port_sel <= '0;
            r_tx_en    <= 1'b0;
            r_txd      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_GRANT;
                        r_grant_id <= w_winner;
                        r_rr_ptr   <= w_ptr_next;
                        r_port_sel <= w_onehot;
                        r_cnt      <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_done || w_timeout) begin
                        r_state    <= ST_GAP;
                        r_port_sel <= '0;
                        r_cnt      <= '0;
                    end else if (TO_EN) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == IFG_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_port_sel <= '0;
                    r_cnt      <= '0;
                end
            endcase

            // GAP keeps the mux open so trailing bytes of the granted frame drain out.
            if (r_state != ST_IDLE) begin
                r_tx_en <= w_sel_en;
                r_txd   <= w_sel_txd;
            end else begin
                r_tx_en <= 1'b0;
                r_txd   <= '0;
            end
        end
    end

    assign port_sel      = r_port_sel;
    assign gmii_tx_en    = r_tx_en;
    assign gmii_txd      = r_txd;
    assign grant_id      = r_grant_id;
    assign busy          = (r_state != ST_IDLE);
    assign timeout_pulse = w_timeout;

endmodule

// File: doc/eth_tx_arbiter_n.md
ETH_TX_ARBITER_N -- requirements
Module: eth_tx_arbiter_n

Interface
REQ-001 SHALL have parameter PORT_NUM, default 3, number of GMII transmit sources (legal 2..8).
REQ-002 SHALL have parameter RR_MODE, default 1: 0 = fixed priority with port 0 highest; 1 = round-robin.
REQ-003 SHALL have parameter IFG_CYCLES, default 12, idle cycles forced between grants (0 allowed).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum grant length in cycles (0 disables the timeout).
REQ-005 SHALL define ID_W = max(1, clog2(PORT_NUM)).
REQ-006 clk  input  1  single clock (gmii tx clock domain); all logic on its rising edge.
REQ-007 rstn  input  1  asynchronous, active-low reset.
REQ-008 port_req  input  PORT_NUM  per-port transmit request, level.
REQ-009 port_done  input  PORT_NUM  per-port frame-complete pulse.
REQ-010 port_sel  output  PORT_NUM  one-hot grant to the ports.
REQ-011 port_tx_en  input  PORT_NUM  per-port GMII tx enable.
REQ-012 port_txd  input  8*PORT_NUM  per-port GMII data; port i occupies bits [8i+7:8i].
REQ-013 gmii_tx_en  output  1  muxed GMII tx enable.
REQ-014 gmii_txd  output  8  muxed GMII data.
REQ-015 grant_id  output  ID_W  index of the current or last granted port.
REQ-016 busy  output  1  high whenever the state is not IDLE.
REQ-017 timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-018 SHALL implement the states IDLE, GRANT and GAP.
REQ-019 In IDLE with any port_req bit high, SHALL choose a winner, load grant_id, and go to GRANT; port_sel SHALL be asserted on the next cycle (1-cycle request-to-grant latency).
REQ-020 With RR_MODE=0, the winner SHALL be the lowest-index requesting port.
REQ-021 With RR_MODE=1, the search SHALL start at (last grant_id+1) mod PORT_NUM and wrap around; after reset it SHALL start at port 0.
REQ-022 In GRANT, port_sel SHALL be one-hot at bit grant_id and held; deasserting port_req SHALL NOT release the grant.
REQ-023 In GRANT, port_done[grant_id]=1 SHALL move the state to GAP; port_done from any non-granted port SHALL be ignored.
REQ-024 In GRANT with TIMEOUT_CYCLES>0, a cycle counter SHALL start at 0 on entry, and its reaching TIMEOUT_CYCLES-1 without a done SHALL move the state to GAP and pulse timeout_pulse for one cycle.
REQ-025 If done and timeout occur in the same cycle, done SHALL take precedence and timeout_pulse SHALL stay 0.
REQ-026 In GAP, SHALL count IFG_CYCLES cycles and then enter IDLE; with IFG_CYCLES=0, GAP SHALL last exactly 1 cycle.
REQ-027 port_sel SHALL be all zero in IDLE and GAP.
REQ-028 gmii_tx_en/gmii_txd SHALL be registered copies of port_tx_en[grant_id]/port_txd[grant_id] whenever the state is GRANT or GAP (so trailing bytes pass through), else 0 (1-cycle latency).
REQ-029 Counters SHALL be sized to hold max(IFG_CYCLES, TIMEOUT_CYCLES) without overflow.
REQ-030 A request arriving during GAP SHALL be served only after the return to IDLE.

Reset
REQ-031 While rstn=0: state IDLE, port_sel=0, gmii_tx_en=0, gmii_txd=0, grant_id=0, busy=0, timeout_pulse=0, RR pointer=0, counters=0.
REQ-032 Reset asserted mid-GRANT SHALL drop port_sel and the GMII outputs asynchronously, with no completion of the in-flight grant after release.

Verification
REQ-033 PORT_NUM=3, RR_MODE=0, port_req=3'b110 -> port_sel=3'b010 one cycle later; done[1] -> GAP of 12 cycles; port_req still 3'b100 -> port_sel=3'b100.
REQ-034 RR_MODE=1, all three ports requesting continuously, each done issued 20 cycles after grant -> grant order 0,1,2,0,1,2.
REQ-035 Granted port 2 streams tx_en=1 with txd=0x55..0xD5 while port 0 drives 0xFF -> gmii_txd equals port 2 data delayed one cycle; gmii_tx_en=0 in IDLE.
REQ-036 TIMEOUT_CYCLES=16, grant given with no done -> timeout_pulse high on the 16th GRANT cycle, then GAP; a case with done and timeout in the same cycle -> no pulse.
REQ-037 port_done[0] pulsed while port 1 is granted -> grant unchanged; rstn dropped mid-GRANT -> port_sel=0 and gmii_tx_en=0 immediately, grant_id=0.
REQ-038 IFG_CYCLES=0, back-to-back requests -> exactly 1 GAP cycle between port_sel pulses.
